// File: rtl/popcount_pkg.sv
// popcount_pkg: shared FSM state type and count-width helper for the sequential popcount
package popcount_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  function automatic int cnt_w(input int w);
    return $clog2(w) + 1;
  endfunction
endpackage

// File: rtl/num_ones_for.sv
// num_ones_for: combinational count of 1 bits in a WIDTH-bit word
module num_ones_for
  import popcount_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0]      i_data,
  output logic [$clog2(WIDTH):0] o_ones
);
  // sum the bits one at a time
  always_comb begin
    o_ones = '0;
    for (int i = 0; i < WIDTH; i++) o_ones = o_ones + ($clog2(WIDTH)+1)'(i_data[i]);
  end
endmodule

// File: rtl/popcount_seq.sv
// popcount_seq: counts the 1 bits of a word CHUNK bits per cycle behind a valid/ready handshake
module popcount_seq
  import popcount_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [$clog2(WIDTH):0] out_ones,
  output logic                  busy
);
  localparam int NUM_CHUNKS = WIDTH / CHUNK;
  localparam int CNT_W      = cnt_w(WIDTH);
  localparam int CW         = NUM_CHUNKS > 1 ? $clog2(NUM_CHUNKS) : 1;
  localparam int CH_W       = cnt_w(CHUNK);

  if (CHUNK < 1 || WIDTH % CHUNK != 0) begin : g_bad_chunk
    $error("popcount_seq: CHUNK must be >= 1 and divide WIDTH");
  end

  state_t           r_state, w_next;
  logic [WIDTH-1:0] r_shreg;
  logic [CNT_W-1:0] r_acc, r_res, w_sum;
  logic [CW-1:0]    r_cnt;
  logic [CH_W-1:0]  w_chunk;
  logic             w_accept, w_last;

  num_ones_for #(.WIDTH(CHUNK)) u_chunk (.i_data(r_shreg[CHUNK-1:0]), .o_ones(w_chunk));

  assign w_sum     = r_acc + CNT_W'(w_chunk);
  assign w_last    = r_cnt == CW'(NUM_CHUNKS - 1);
  assign in_ready  = (r_state == IDLE) | ((r_state == DONE) & out_ready);
  assign w_accept  = in_valid & in_ready;
  assign out_valid = r_state == DONE;
  assign busy      = r_state != IDLE;
  assign out_ones  = r_res;

  // next state: a DONE handshake with a waiting word goes straight back to RUN
  always_comb begin
    w_next = r_state;
    if (r_state == IDLE) w_next = w_accept ? RUN : IDLE;
    else if (r_state == RUN) w_next = w_last ? DONE : RUN;
    else if (r_state == DONE) w_next = out_ready ? (in_valid ? RUN : IDLE) : DONE;
  end

  // datapath and state: capture on accept, accumulate one chunk per RUN cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_shreg <= '0;
      r_acc   <= '0;
      r_res   <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_shreg <= in_data;
        r_acc   <= '0;
        r_cnt   <= '0;
      end else if (r_state == RUN) begin
        r_shreg <= r_shreg >> CHUNK;
        r_acc   <= w_sum;
        r_cnt   <= w_last ? r_cnt : r_cnt + CW'(1);
        if (w_last) r_res <= w_sum;
      end
    end
  end
endmodule

// File: tb/tb_popcount_seq.sv
// tb_popcount_seq: directed stimulus with a result scoreboard for popcount_seq
module tb_popcount_seq;
  logic        clk = 0, rst = 1;
  logic        in_valid = 0, out_ready = 1;
  logic [31:0] in_data = 0;
  logic        in_ready, out_valid, busy;
  logic [5:0]  out_ones;
  logic        v2 = 0, rdy2, ov2, busy2, or2 = 1;
  logic [7:0]  d2 = 0;
  logic [3:0]  oo2;
  int          n_chk = 0, n_fail = 0;
  int          exp_q[$];
  int          lat, b2b, seen;

  popcount_seq #(.WIDTH(32), .CHUNK(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_ones(out_ones), .busy(busy));

  popcount_seq #(.WIDTH(8), .CHUNK(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(v2), .in_ready(rdy2), .in_data(d2),
    .out_valid(ov2), .out_ready(or2), .out_ones(oo2), .busy(busy2));

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // scoreboard: every output handshake must match the oldest accepted word
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) check("unexpected_output", 1, 0);
      else check("scoreboard", int'(out_ones), exp_q.pop_front());
    end
  end

  task automatic send(input logic [31:0] w);
    int k;
    in_valid = 1;
    in_data  = w;
    for (k = 0; k < 50; k++) begin
      @(negedge clk);
      if (in_ready) break;
      @(posedge clk); #1;
    end
    if (k == 50) check("accept_timeout", 0, 1);
    b2b = out_valid;
    exp_q.push_back($countones(w));
    @(posedge clk); #1;
  endtask

  task automatic wait_valid(output int l);
    l = 0;
    while (!out_valid && l < 40) begin
      @(posedge clk); #1;
      l++;
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 0;
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_ones", out_ones, 0);

    send(32'hFFFFFFFF);
    in_valid = 0;
    wait_valid(lat);
    check("ones_latency", lat, 8);
    check("ones_result", out_ones, 32);
    @(posedge clk); #1;
    check("ones_idle_busy", busy, 0);
    check("ones_idle_ready", in_ready, 1);

    send(32'h00000000); in_valid = 0; wait_valid(lat);
    check("zero_result", out_ones, 0);
    send(32'h80000001); in_valid = 0; wait_valid(lat);
    check("edges_result", out_ones, 2);
    send(32'h12345678); in_valid = 0; wait_valid(lat);
    check("mixed_result", out_ones, 13);
    check("mixed_latency", lat, 8);
    @(posedge clk); #1;

    out_ready = 0;
    send(32'h0000FFFF);
    in_valid = 1; in_data = 32'hDEADBEEF;
    wait_valid(lat);
    for (int i = 0; i < 5; i++) begin
      check("stall_valid", out_valid, 1);
      check("stall_ones", out_ones, 16);
      check("stall_ready", in_ready, 0);
      @(posedge clk); #1;
    end
    in_valid = 0;
    out_ready = 1;
    @(posedge clk); #1;
    check("stall_release_valid", out_valid, 0);
    check("stall_release_busy", busy, 0);

    send(32'h0000000F);
    wait_valid(lat);
    check("b2b_first", out_ones, 4);
    send(32'hF0F0F0F0);
    check("b2b_same_edge", b2b, 1);
    in_valid = 0;
    wait_valid(lat);
    check("b2b_latency", lat, 8);
    check("b2b_second", out_ones, 16);
    @(posedge clk); #1;

    send(32'h000000FF);
    in_valid = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1;
    @(posedge clk); #1 rst = 0;
    void'(exp_q.pop_back());
    check("midrst_valid", out_valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_ready", in_ready, 1);
    check("midrst_ones", out_ones, 0);
    seen = 0;
    repeat (12) begin
      @(posedge clk); #1;
      seen |= out_valid;
    end
    check("midrst_no_emit", seen, 0);
    send(32'h00000001); in_valid = 0; wait_valid(lat);
    check("after_rst_result", out_ones, 1);
    @(posedge clk); #1;

    v2 = 1; d2 = 8'hA5;
    @(negedge clk);
    check("w8_ready", rdy2, 1);
    @(posedge clk); #1 v2 = 0;
    check("w8_run_valid", ov2, 0);
    check("w8_run_busy", busy2, 1);
    @(posedge clk); #1;
    check("w8_valid", ov2, 1);
    check("w8_result", oo2, 4);
    @(posedge clk); #1;
    check("w8_idle", busy2, 0);

    check("queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/popcount_seq.md
POPCOUNT_SEQ -- requirements
Module: popcount_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 32: input word width in bits.
REQ-002 SHALL have parameter CHUNK, default 4: bits counted per cycle; WIDTH % CHUNK == 0, CHUNK >= 1. Elaboration SHALL fail otherwise.
REQ-003 SHALL derive NUM_CHUNKS = WIDTH/CHUNK and CNT_W = $clog2(WIDTH)+1; these are not overridable.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 in_valid  input  1  in_data is valid.
REQ-007 in_ready  output  1  block accepts in_data this cycle.
REQ-008 in_data  input  WIDTH  word to count.
REQ-009 out_valid  output  1  out_ones holds a completed result.
REQ-010 out_ready  input  1  consumer takes the result.
REQ-011 out_ones  output  CNT_W  number of 1 bits in the accepted word.
REQ-012 busy  output  1  high whenever the state is not IDLE.

Function
REQ-013 SHALL implement FSM states IDLE, RUN and DONE.
REQ-014 Input handshake SHALL be in_valid & in_ready.
- It SHALL capture in_data into a WIDTH-bit shift register.
- It SHALL clear the accumulator and set the chunk counter to 0.
- Next state SHALL be RUN.
REQ-015 in_ready SHALL equal (state==IDLE) | (state==DONE & out_ready); it is combinational from out_ready.
REQ-016 In RUN, each cycle:
- shreg[CHUNK-1:0] SHALL feed the chunk counter.
- acc SHALL load acc + chunk count.
- shreg SHALL shift right by CHUNK.
- The chunk counter SHALL increment.
REQ-017 RUN SHALL go to DONE on the cycle the chunk counter == NUM_CHUNKS-1. On that same edge the result register SHALL load the final sum.
REQ-018 Latency SHALL be exactly NUM_CHUNKS cycles: acceptance at edge N SHALL give out_valid high after edge N+NUM_CHUNKS. Latency SHALL not depend on the data.
REQ-019 out_valid SHALL be high only in DONE.
REQ-020 out_ones SHALL be driven from the result register. It SHALL change only on RUN->DONE and SHALL hold between results.
REQ-021 In DONE with out_ready=0, out_valid and out_ones SHALL hold stable and in_ready SHALL be 0.
REQ-022 DONE with out_ready=1 and in_valid=0 SHALL go to IDLE.
REQ-023 DONE with out_ready=1 and in_valid=1 SHALL do the output handshake and the new input capture on the same edge, then go to RUN (back-to-back, no bubble).
REQ-024 in_data SHALL be ignored whenever in_ready=0.
REQ-025 NUM_CHUNKS==1 SHALL spend exactly one cycle in RUN.
REQ-026 acc and the result register SHALL be CNT_W bits. An all-ones WIDTH word SHALL yield WIDTH with no overflow.
REQ-027 The chunk counter SHALL be $clog2(NUM_CHUNKS) bits (minimum 1) and SHALL not wrap within a word.

Reset
REQ-028 On rst=1, on the next edge:
- state SHALL be IDLE.
- acc, result register, chunk counter and shreg SHALL be 0.
- out_valid SHALL be 0, busy 0, in_ready 1 (out_ones=0).
REQ-029 rst SHALL take priority over any simultaneous handshake. A word in RUN or DONE at reset SHALL be discarded and never emitted.

Structure
REQ-030 Package popcount_pkg SHALL hold the state enum typedef (IDLE/RUN/DONE) and a count-width function returning $clog2(w)+1.
REQ-031 SHALL instantiate exactly one existing num_ones_for with WIDTH=CHUNK as the per-chunk counter. Its output SHALL be zero-extended to CNT_W before the add.
REQ-032 All sequential logic SHALL be in one clocked process with synchronous reset. There SHALL be no latches.

Verification (WIDTH=32, CHUNK=4 unless stated)
REQ-033 in_data=0xFFFFFFFF, out_ready=1 -> out_valid 8 cycles after acceptance, out_ones=32; then IDLE, busy=0.
REQ-034 Words 0x00000000, 0x80000001, 0x12345678 -> out_ones 0, 2, 13 respectively.
REQ-035 in_data=0x0000FFFF, out_ready held 0 for 5 cycles after out_valid -> out_ones=16 stable and in_ready=0 throughout. Then out_ready=1 -> one handshake only.
REQ-036 Continuous in_valid with 0x0000000F then 0xF0F0F0F0, out_ready=1 -> results 4 then 16. The second word is captured on the edge of the first output handshake, and the second out_valid comes 8 cycles later.
REQ-037 rst pulsed 3 cycles into RUN -> next cycle out_valid=0, busy=0, in_ready=1, out_ones=0, and no result emitted. A following word 0x00000001 -> out_ones=1.
REQ-038 WIDTH=8, CHUNK=8: in_data=0xA5 -> out_valid 1 cycle after acceptance, out_ones=4. WIDTH=8, CHUNK=3 -> elaboration error.
